// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Shares the start/busy stall handshake used by the iterative divider.
module mul_seq #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cache_stall,
  input  logic               start,
  input  logic [1:0]         mul_ctrl,
  input  logic [D_WIDTH-1:0] multiplicand,
  input  logic [D_WIDTH-1:0] multiplier,
  output logic [D_WIDTH-1:0] result,
  output logic               mul_busy
);

  typedef enum logic [1:0] {IDLE, INIT, MULT, DONE} state_t;

  localparam logic [1:0] CTRL_MUL    = 2'b00;
  localparam logic [1:0] CTRL_MULH   = 2'b01;
  localparam logic [1:0] CTRL_MULHSU = 2'b10;
  localparam logic [4:0] LAST_ITER   = 5'd31;

  state_t               state_q, state_d;
  logic [4:0]           counter_q, counter_d;
  logic                 start_q, busy_q;
  logic [D_WIDTH-1:0]   mcand_q, mcand_d;
  logic [D_WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [D_WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [D_WIDTH-1:0]   result_q, result_d;
  logic                 sign_p_q, sign_p_d;
  logic                 start_pulse;
  logic                 rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [D_WIDTH:0]     sum;
  logic [2*D_WIDTH-1:0] product;

  // start_q masks the still-high start of the op that just finished
  assign start_pulse = start & ~start_q & ~cache_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_pulse) state_d = INIT;
      INIT:    state_d = MULT;
      MULT:    if (counter_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_busy = start & busy_q;
    result   = result_q;
  end

  // Operands are latched raw on launch; INIT converts them to magnitudes in place
  always_comb begin
    mcand_d    = mcand_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    sign_p_d   = sign_p_q;
    counter_d  = counter_q;
    result_d   = result_q;
    rs1_signed = (mul_ctrl == CTRL_MULH) || (mul_ctrl == CTRL_MULHSU);
    rs2_signed = (mul_ctrl == CTRL_MULH);
    rs1_neg    = rs1_signed & mcand_q[D_WIDTH-1];
    rs2_neg    = rs2_signed & acc_lo_q[D_WIDTH-1];
    sum        = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    product    = sign_p_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    case (state_q)
      IDLE: begin
        counter_d = '0;
        if (start_pulse) begin
          mcand_d  = multiplicand;
          acc_lo_d = multiplier;
        end
      end
      INIT: begin
        mcand_d  = rs1_neg ? -mcand_q : mcand_q;
        acc_lo_d = rs2_neg ? -acc_lo_q : acc_lo_q;
        acc_hi_d = '0;
        sign_p_d = rs1_neg ^ rs2_neg;
      end
      MULT: begin
        counter_d            = counter_q + 5'd1;
        {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[D_WIDTH-1:1]};
      end
      DONE: begin
        counter_d = '0;
        result_d  = (mul_ctrl == CTRL_MUL) ? product[D_WIDTH-1:0]
                                           : product[2*D_WIDTH-1:D_WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b1;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      sign_p_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      counter_q <= counter_d;
      start_q   <= (state_q != IDLE);
      busy_q    <= (state_q != DONE);
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      sign_p_q  <= sign_p_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: scoreboard of expected products, latency,
// cache_stall gating, back-to-back launches and mid-operation reset.
module tb_mul_seq;

  localparam int LATENCY = 35;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_stall;
  logic        start;
  logic [1:0]  mul_ctrl;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] result;
  logic        mul_busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  mul_seq #(.D_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cache_stall  (cache_stall),
    .start        (start),
    .mul_ctrl     (mul_ctrl),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .mul_busy     (mul_busy)
  );

  always #5 clk = ~clk;

  // Reference: extend each operand to 64 bits by its signedness, multiply mod 2^64
  function automatic logic [31:0] model(input logic [1:0] ctrl, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (ctrl == 2'b01 || ctrl == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (ctrl == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (ctrl == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    mul_ctrl     = ctrl;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(model(ctrl, a, b));
  endtask

  // Counts cycles with mul_busy high, starting in the current cycle
  task automatic wait_done(output int cycles);
    cycles = 0;
    #1;
    while (mul_busy === 1'b1 && cycles < TIMEOUT) begin
      cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cache_stall = 1'b0;
    mul_ctrl = 2'b00; multiplicand = '0; multiplier = '0;
    step(); step();
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_result: got %h expected %h", result, 32'h0);
    end
    checks++;
    if (mul_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy_idle: got %b expected %b", mul_busy, 1'b0);
    end
    start = 1'b1;
    #1;
    checks++;
    if (mul_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_busy_start: got %b expected %b", mul_busy, 1'b1);
    end
    start = 1'b0;
    rst   = 1'b0;
    step(); step();
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] exp;
    launch(2'b00, 32'd7, 32'd6);
    wait_done(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", cyc, LATENCY);
    end
    checks++;
    if (mul_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_busy_done: got %b expected %b", mul_busy, 1'b0);
    end
    exp = exp_q.pop_front();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL basic_result: got %h expected %h", result, exp);
    end
    start = 1'b0;
    repeat (5) step();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL basic_hold: got %h expected %h", result, exp);
    end
  endtask

  task automatic test_modes();
    logic [1:0]  ctrl_t[9];
    logic [31:0] a_t[9];
    logic [31:0] b_t[9];
    int          cyc;
    logic [31:0] exp;
    ctrl_t = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
    a_t    = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               $urandom, $urandom, $urandom, $urandom};
    b_t    = '{32'h5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
               $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 9; i++) begin
      launch(ctrl_t[i], a_t[i], b_t[i]);
      wait_done(cyc);
      checks++;
      if (cyc !== LATENCY) begin
        errors++; $display("[TB] FAIL modes_latency[%0d]: got %0d expected %0d", i, cyc, LATENCY);
      end
      exp = exp_q.pop_front();
      checks++;
      if (result !== exp) begin
        errors++;
        $display("[TB] FAIL modes_result[%0d] ctrl=%b a=%h b=%h: got %h expected %h",
                 i, ctrl_t[i], a_t[i], b_t[i], result, exp);
      end
      start = 1'b0;
      step(); step();
    end
  endtask

  task automatic test_cache_stall();
    int cyc;
    logic [31:0] exp;
    cache_stall = 1'b1;
    launch(2'b11, 32'h89ABCDEF, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mul_busy !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_busy[%0d]: got %b expected %b", i, mul_busy, 1'b1);
      end
      step();
    end
    cache_stall = 1'b0;
    step();
    multiplicand = ~multiplicand;
    multiplier   = $urandom;
    wait_done(cyc);
    cyc = cyc + 1;
    checks++;
    if (cyc !== LATENCY) begin
      errors++; $display("[TB] FAIL stall_latency: got %0d expected %0d", cyc, LATENCY);
    end
    exp = exp_q.pop_front();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL stall_result: got %h expected %h", result, exp);
    end
    start = 1'b0;
    step(); step();
    // A stall arriving mid-operation must not freeze the iteration
    launch(2'b01, 32'hFFFFFFF0, 32'h00000003);
    cyc = 0;
    #1;
    while (mul_busy === 1'b1 && cyc < TIMEOUT) begin
      cyc++;
      step();
      cache_stall = (cyc >= 10 && cyc < 15);
    end
    checks++;
    if (cyc !== LATENCY) begin
      errors++; $display("[TB] FAIL stall_inflight_latency: got %0d expected %0d", cyc, LATENCY);
    end
    exp = exp_q.pop_front();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL stall_inflight_result: got %h expected %h", result, exp);
    end
    cache_stall = 1'b0;
    start = 1'b0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] exp;
    launch(2'b00, 32'd3, 32'd4);
    wait_done(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", cyc, LATENCY);
    end
    exp = exp_q.pop_front();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL b2b_first_result: got %h expected %h", result, exp);
    end
    launch(2'b00, 32'd5, 32'd6);
    step();
    checks++;
    if (mul_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_second_busy_c36: got %b expected %b", mul_busy, 1'b1);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", cyc, LATENCY);
    end
    exp = exp_q.pop_front();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL b2b_second_result: got %h expected %h", result, exp);
    end
    start = 1'b0;
    repeat (40) step();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL b2b_no_extra_op: got %h expected %h", result, exp);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    logic [31:0] exp;
    mul_ctrl     = 2'b11;
    multiplicand = 32'h12345678;
    multiplier   = 32'h9ABCDEF0;
    start        = 1'b1;
    repeat (12) step();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_result: got %h expected %h", result, 32'h0);
    end
    checks++;
    if (mul_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_busy_start: got %b expected %b", mul_busy, 1'b1);
    end
    start = 1'b0;
    #1;
    checks++;
    if (mul_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_busy_nostart: got %b expected %b", mul_busy, 1'b0);
    end
    step();
    rst = 1'b0;
    repeat (40) step();
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_no_publish: got %h expected %h", result, 32'h0);
    end
    launch(2'b00, 32'd9, 32'd9);
    wait_done(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      errors++; $display("[TB] FAIL midrst_fresh_latency: got %0d expected %0d", cyc, LATENCY);
    end
    exp = exp_q.pop_front();
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL midrst_fresh_result: got %h expected %h", result, exp);
    end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_cache_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Sits in the ALU alongside the iterative divider and uses the same start/busy stall handshake toward the pipeline.
- Latches operands on a qualified start edge, runs 32 add-shift iterations, then publishes the selected 32-bit half of the 64-bit product.

Parameters:
- D_WIDTH, 32, operand/result width; counter, state and iteration count are sized for 32.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cache_stall  input  1  pipeline frozen by cache; suppresses start qualification
- start  input  1  mul_en, held high by the pipeline while a multiply sits in EX
- mul_ctrl  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- multiplicand  input  D_WIDTH  op1 (rs1, forwarded value)
- multiplier  input  D_WIDTH  op2 (rs2, forwarded value)
- result  output  D_WIDTH  selected product half, registered
- mul_busy  output  1  stall request to the pipeline

Behaviour:
- Clock clk; reset rst, asynchronous, active-high.
- Reset values: state=IDLE, counter=0, start_q=0, busy_q=1, result=0. mul_busy=start&busy_q, so it is 0 after reset unless start is high.
- start_pulse = start & ~start_q & ~cache_stall.
- start_q is registered: it becomes (state!=IDLE) on every edge.
- busy_q is registered: it becomes (state!=DONE) on every edge.
- FSM transitions:
  - IDLE -> INIT on start_pulse; operands are latched into internal regs on that same edge.
  - INIT -> MULT unconditionally.
  - MULT -> DONE when counter==31.
  - DONE -> IDLE unconditionally.
- counter: cleared in IDLE and DONE; increments in MULT.
- INIT:
  - Magnitudes: rs1 is treated as signed for MULH and MULHSU; rs2 is treated as signed for MULH only.
  - A signed operand is replaced by its two's-complement magnitude when its bit 31 is set.
  - sign_p = sign(rs1 as treated) XOR sign(rs2 as treated).
  - MUL and MULHU use raw unsigned operands and sign_p=0; MUL's low half is sign-independent.
  - Clear the 64-bit accumulator {acc_hi, acc_lo}; load the magnitude of rs2 into acc_lo.
- MULT, per cycle:
  - sum[32:0] = acc_hi + (acc_lo[0] ? mcand_mag : 0), with the carry kept.
  - {acc_hi, acc_lo} <= {sum, acc_lo[31:1]}, i.e. a 65-bit right shift by one.
  - After 32 iterations {acc_hi, acc_lo} holds the unsigned 64-bit product of the magnitudes.
- DONE: p = sign_p ? -{acc_hi,acc_lo} : {acc_hi,acc_lo} (64-bit negate). result <= p[31:0] for MUL, p[63:32] for the other three.
- Latency, with cycle 0 = start_pulse: INIT in cycle 1, MULT in cycles 2..33, DONE in cycle 34, result valid and mul_busy=0 in cycle 35.
- mul_busy is high from the first cycle start rises through cycle 34. result holds until the next DONE.
- Back-to-back: busy_q returns to 1 in cycle 36 and start_q returns to 0 in cycle 36. A following multiply, with start still high, pulses in cycle 36 and stalls correctly.
- cache_stall:
  - Only gates start_pulse. An operation already in flight continues iterating during cache_stall.
  - If cache_stall is high when start rises, the launch waits until cache_stall falls; mul_busy stays high meanwhile.
- Operands changing after the latch edge do not affect the result (forwarding safety).
- Reset mid-operation aborts immediately: state=IDLE, result=0, no partial result is published.
- mul_ctrl is sampled live in INIT and DONE. The pipeline holds it stable while mul_busy is high.

Test Plan:
- MUL 7 x 6, start held high -> mul_busy high for 35 cycles; result=0x0000002A in cycle 35; mul_busy=0.
- MUL 0xFFFFFFFD x 5 -> 0xFFFFFFF1. MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULH 0xFFFFFFFF x 0x00000001 -> 0xFFFFFFFF.
- cache_stall high for 3 cycles as start rises -> no launch until it drops; latency measured from the drop is 35; result correct. Toggling operands after the latch edge leaves the result unchanged.
- Two consecutive MULs (3x4 then 5x6) with start held continuously -> results 12 then 30; the second launch pulses in cycle 36; no lost or duplicated operation.
- Assert rst during MULT iteration 10 -> state IDLE, result=0, mul_busy=start. A fresh MUL 9x9 afterwards -> 0x51.
